// File: rtl/shift_pkg.sv
// Shared types for the sequential shift/rotate engine: operation modes and FSM states.
package shift_pkg;

    // Operation selector; encodings 5..7 are reserved and flagged as errors.
    typedef enum logic [2:0] {
        MODE_LSL  = 3'd0,
        MODE_LSR  = 3'd1,
        MODE_ASR  = 3'd2,
        MODE_ROTL = 3'd3,
        MODE_ROTR = 3'd4
    } shift_mode_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // True for any encoding outside MODE_LSL..MODE_ROTR.
    function automatic logic mode_is_reserved(input logic [2:0] mode);
        return (mode > 3'd4);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies up to STEP bits of one operation per cycle.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_mode,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [AMT_W-1:0] w_inv_amt;
    logic [WIDTH-1:0] w_sign_mask;

    // Select the shifted result; ASR fills the vacated top bits with the latched sign.
    always_comb begin
        w_inv_amt   = W_AMT - i_amt;
        w_sign_mask = (~(ONES >> i_amt)) & {WIDTH{i_sign}};
        case (i_mode)
            MODE_LSL:  o_data = i_data << i_amt;
            MODE_LSR:  o_data = i_data >> i_amt;
            MODE_ASR:  o_data = (i_data >> i_amt) | w_sign_mask;
            MODE_ROTL: o_data = (i_data << i_amt) | (i_data >> w_inv_amt);
            MODE_ROTR: o_data = (i_data >> i_amt) | (i_data << w_inv_amt);
            default:   o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate engine with valid/ready operand and result handshakes.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam logic [AMT_W-1:0] W_AMT    = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    shift_state_t     r_state;
    shift_state_t     w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_mode;
    logic             r_sign;
    logic             r_err;
    logic [AMT_W-1:0] r_rem;

    logic             w_accept;
    logic             w_reserved;
    logic [AMT_W-1:0] w_eff_amt;
    logic [AMT_W-1:0] w_step_amt;
    logic [WIDTH-1:0] w_step_data;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_reserved = mode_is_reserved(in_mode);

    // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH, reserved is a no-op.
    always_comb begin
        if (w_reserved) begin
            w_eff_amt = '0;
        end else if ((in_mode == MODE_ROTL) || (in_mode == MODE_ROTR)) begin
            w_eff_amt = in_amt % W_AMT;
        end else if (in_amt > W_AMT) begin
            w_eff_amt = W_AMT;
        end else begin
            w_eff_amt = in_amt;
        end
    end

    // Bits applied this cycle: the remainder, capped at STEP.
    always_comb begin
        w_step_amt = (r_rem > STEP_AMT) ? STEP_AMT : r_rem;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .i_data (r_data),
        .i_mode (r_mode),
        .i_amt  (w_step_amt),
        .i_sign (r_sign),
        .o_data (w_step_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; zero-length operations skip straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_eff_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_rem <= STEP_AMT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    // Operand capture on accept, then one step per cycle while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_mode <= 3'd0;
            r_sign <= 1'b0;
            r_err  <= 1'b0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_mode <= in_mode;
            r_sign <= in_data[WIDTH-1];
            r_err  <= w_reserved;
            r_rem  <= w_eff_amt;
        end else if (r_state == SHIFT) begin
            r_data <= w_step_data;
            r_rem  <= r_rem - w_step_amt;
        end
    end

    assign out_data = r_data;
    assign out_err  = r_err;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: one instance with STEP=1 (a_) and one with STEP=2 (b_).
module tb_shift_seq_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_busy;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_in_mode;
    logic [3:0] a_in_amt;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_busy;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_in_mode;
    logic [3:0] b_in_amt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_seq_unit #(.WIDTH(8), .STEP(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_amt(a_in_amt),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .busy(a_busy)
    );

    shift_seq_unit #(.WIDTH(8), .STEP(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_amt(b_in_amt),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err(b_out_err), .busy(b_busy)
    );

    // Issue one operation with out_ready high; lat = edges after accept until out_valid (-1 on timeout).
    task automatic run_op(input bit sel, input logic [2:0] mode, input logic [7:0] d,
                          input logic [3:0] amt, output logic [7:0] res, output logic err,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        if (sel) begin
            b_in_data = d; b_in_mode = mode; b_in_amt = amt; b_in_valid = 1'b1; b_out_ready = 1'b1;
        end else begin
            a_in_data = d; a_in_mode = mode; a_in_amt = amt; a_in_valid = 1'b1; a_out_ready = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_data = 8'h00; b_in_data = 8'h00; a_in_amt = 4'd0; b_in_amt = 4'd0;
        lat = 0;
        busy_cyc = 0;
        while (!(sel ? b_out_valid : a_out_valid) && lat < 40) begin
            if (sel ? b_busy : a_busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) lat = -1;
        if (sel ? b_busy : a_busy) busy_cyc++;
        res = sel ? b_out_data : a_out_data;
        err = sel ? b_out_err : a_out_err;
        @(posedge clk); #1;
        if (sel ? b_busy : a_busy) busy_cyc++;
        $display("op unit=%0d mode=%0d data=0x%02h amt=%0d -> res=0x%02h err=%0b lat=%0d busy=%0d",
                 sel, mode, d, amt, res, err, lat, busy_cyc);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_busy, a_out_err, a_out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_a: got rdy=%0b vld=%0b busy=%0b err=%0b data=0x%02h, want 1 0 0 0 0x00",
                     a_in_ready, a_out_valid, a_busy, a_out_err, a_out_data);
        end
        n_cmp++;
        if ({b_in_ready, b_out_valid, b_busy, b_out_err, b_out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_b: got rdy=%0b vld=%0b busy=%0b err=%0b data=0x%02h, want 1 0 0 0 0x00",
                     b_in_ready, b_out_valid, b_busy, b_out_err, b_out_data);
        end
    endtask

    task automatic test_lsl();
        logic [7:0] r; logic e; int l, bc;
        run_op(1'b0, 3'd0, 8'h81, 4'd1, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h02, 1'b0} || l !== 1) begin
            n_fail++;
            $display("FAIL lsl_step1: got 0x%02h err=%0b lat=%0d, want 0x02 err=0 lat=1", r, e, l);
        end
    endtask

    task automatic test_asr_step2();
        logic [7:0] r; logic e; int l, bc;
        run_op(1'b1, 3'd2, 8'h90, 4'd3, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'hF2, 1'b0} || l !== 2) begin
            n_fail++;
            $display("FAIL asr_step2: got 0x%02h err=%0b lat=%0d, want 0xF2 err=0 lat=2", r, e, l);
        end
        n_cmp++;
        if (bc !== 3) begin
            n_fail++;
            $display("FAIL asr_busy: got %0d busy cycles, want 3", bc);
        end
        run_op(1'b1, 3'd3, 8'h81, 4'd3, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h0C, 1'b0} || l !== 2) begin
            n_fail++;
            $display("FAIL rotl_step2: got 0x%02h err=%0b lat=%0d, want 0x0C err=0 lat=2", r, e, l);
        end
    endtask

    task automatic test_rotate_wrap();
        logic [7:0] r; logic e; int l, bc;
        run_op(1'b0, 3'd4, 8'h01, 4'd9, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h80, 1'b0} || l !== 1) begin
            n_fail++;
            $display("FAIL rotr_wrap: got 0x%02h err=%0b lat=%0d, want 0x80 err=0 lat=1", r, e, l);
        end
        run_op(1'b0, 3'd3, 8'h80, 4'd8, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h80, 1'b0} || l !== 0) begin
            n_fail++;
            $display("FAIL rotl_zero: got 0x%02h err=%0b lat=%0d, want 0x80 err=0 lat=0", r, e, l);
        end
    endtask

    task automatic test_over_range();
        logic [7:0] r; logic e; int l, bc;
        run_op(1'b0, 3'd1, 8'hFF, 4'd12, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h00, 1'b0} || l !== 8) begin
            n_fail++;
            $display("FAIL lsr_clamp: got 0x%02h err=%0b lat=%0d, want 0x00 err=0 lat=8", r, e, l);
        end
        run_op(1'b0, 3'd2, 8'h80, 4'd15, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'hFF, 1'b0} || l !== 8) begin
            n_fail++;
            $display("FAIL asr_clamp: got 0x%02h err=%0b lat=%0d, want 0xFF err=0 lat=8", r, e, l);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] r; int l;
        // LSL 0x03 by 2 with the consumer stalled.
        @(negedge clk);
        a_in_data = 8'h03; a_in_mode = 3'd0; a_in_amt = 4'd2; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        l = 0;
        while (!a_out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        n_cmp++;
        if (l !== 2) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d edges, want 2", l);
        end
        // Pending operand presented while stalled: ROTR 0x01 by 1.
        @(negedge clk);
        a_in_data = 8'h01; a_in_mode = 3'd4; a_in_amt = 4'd1; a_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({a_out_valid, a_in_ready, a_out_data, a_out_err} !== {1'b1, 1'b0, 8'h0C, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got vld=%0b rdy=%0b data=0x%02h err=%0b, want 1 0 0x0C 0",
                         c, a_out_valid, a_in_ready, a_out_data, a_out_err);
            end
        end
        $display("bp result held 0x%02h for 5 cycles", a_out_data);
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_busy} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%0b rdy=%0b busy=%0b, want 0 1 0", a_out_valid, a_in_ready, a_busy);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_cmp++;
        if ({a_busy, a_in_ready} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_pending_accept: got busy=%0b rdy=%0b, want 1 0", a_busy, a_in_ready);
        end
        l = 0;
        while (!a_out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        r = a_out_data;
        n_cmp++;
        if (r !== 8'h80 || l !== 1) begin
            n_fail++;
            $display("FAIL bp_pending_result: got 0x%02h lat=%0d, want 0x80 lat=1", r, l);
        end
        $display("bp pending op -> res=0x%02h lat=%0d", r, l);
        @(posedge clk); #1;
    endtask

    task automatic test_reserved();
        logic [7:0] r; logic e; int l, bc;
        run_op(1'b0, 3'd6, 8'h5A, 4'd3, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h5A, 1'b1} || l !== 0) begin
            n_fail++;
            $display("FAIL reserved_mode: got 0x%02h err=%0b lat=%0d, want 0x5A err=1 lat=0", r, e, l);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] r; logic e; int l, bc;
        bit seen;
        @(negedge clk);
        a_in_data = 8'hFF; a_in_mode = 3'd1; a_in_amt = 4'd12; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_busy !== 1'b1 || a_out_data !== 8'h1F) begin
            n_fail++;
            $display("FAIL mid_shift: got busy=%0b data=0x%02h, want 1 0x1F", a_busy, a_out_data);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_busy, a_out_err, a_out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%0b vld=%0b busy=%0b err=%0b data=0x%02h, want 1 0 0 0 0x00",
                     a_in_ready, a_out_valid, a_busy, a_out_err, a_out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (a_out_valid || a_busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got a result or busy after abort, want none");
        end
        $display("reset mid-op: outputs cleared, no result produced");
        run_op(1'b0, 3'd0, 8'h81, 4'd1, r, e, l, bc);
        n_cmp++;
        if ({r, e} !== {8'h02, 1'b0} || l !== 1) begin
            n_fail++;
            $display("FAIL post_reset_op: got 0x%02h err=%0b lat=%0d, want 0x02 err=0 lat=1", r, e, l);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_in_mode = 3'd0; a_in_amt = 4'd0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_mode = 3'd0; b_in_amt = 4'd0; b_out_ready = 1'b0;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_lsl();
        test_asr_step2();
        test_rotate_wrap();
        test_over_range();
        test_back_pressure();
        test_reserved();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
